pipe_skid_stage: RTL

- Parametrised elastic pipeline stage register. It is the successor to the fixed enable/clear stage registers between IF/ID/EX/MEM/WB.
- Replaces the global stall/flush enable scheme with a valid/ready handshake per stage. A 2-entry skid buffer gives full throughput with a registered in_ready.
- Carries an opaque WIDTH-bit payload (packed stage struct, flattened by the caller).
- Supports a synchronous flush that converts the stage contents into bubbles.

---
 rtl/pipe_skid_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pipe_skid_stage.sv
// ============================================================================
// pipe_skid_stage : elastic valid/ready pipeline stage with a 2-entry skid
//                   buffer, registered in_ready/out_valid and synchronous flush.
// Optional: define PIPE_SKID_STATS_EN to add a saturating stall counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_skid_stage #(
    parameter int WIDTH      = 32,
    parameter bit FLUSH_ZERO = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               in_ready_q, out_valid_q;
    logic [1:0]         occupancy_q, occupancy_d;

    if (WIDTH < 1) begin : g_bad_width
        $error("pipe_skid_stage: WIDTH must be >= 1");
    end

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_skid_stage: CNT_W must be >= 1");
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            if (FLUSH_ZERO) begin
                main_d = '0;
                skid_d = '0;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_valid) begin
                        main_d  = in_data;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    unique case ({in_valid, out_ready})
                        2'b11: main_d = in_data;
                        2'b10: begin
                            skid_d  = in_data;
                            state_d = FULL;
                        end
                        2'b01: state_d = EMPTY;
                        default: state_d = BUSY;
                    endcase
                end
                FULL: begin
                    // in_ready is low here, so only the skid entry moves up
                    if (out_ready) begin
                        main_d  = skid_q;
                        state_d = BUSY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        unique case (state_d)
            BUSY:    occupancy_d = 2'd1;
            FULL:    occupancy_d = 2'd2;
            default: occupancy_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d != EMPTY);
            occupancy_q <= occupancy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = occupancy_q;

`ifdef PIPE_SKID_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && state_d == FULL && state_q != FULL) begin
            $display("%0t pipe_skid_stage: FULL entry, occupancy=%0d", $time, occupancy_d);
        end
    end
`endif
`else
`endif

endmodule

`default_nettype wire
